gemv_skew_feeder: RTL

Drives the A-operand inputs of the GEMV systolic array. Accepts one SZ-element vector per handshake and emits it diagonally skewed: lane j is delayed j cycles and zeros are inserted in gaps. Replaces hand-written skewed stimulus and sits between the operand source and the array's A inputs. After the last vector it drains the skew, then pulses done.

---
 rtl/gemv_skew_feeder.sv | 114 +++++++++++
 1 files changed

// File: rtl/gemv_skew_feeder.sv
// gemv_skew_feeder: accepts one SZ-lane operand vector per handshake and
// emits it diagonally skewed onto the systolic array A inputs (lane j is
// delayed j cycles). Gaps between vectors become zero bubbles. After the
// vector flagged in_last, the skew drains and done pulses for one cycle.
//
// Handshake: a vector is taken on a rising clk edge where in_valid && in_ready.
// in_ready depends only on the FSM state (high in IDLE/STREAM), never on
// in_valid. in_vec/in_last are ignored on any cycle without an accept. There is
// no backpressure on the output side: the delay line shifts every cycle.
module gemv_skew_feeder #(
  parameter int DW = 16,
  parameter int SZ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SZ*DW-1:0] in_vec,
  input  logic             in_last,
  output logic [SZ*DW-1:0] a_out,
  output logic [SZ-1:0]    a_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter needs to hold SZ-1; keep at least one bit so SZ=1 stays legal.
  localparam int CW = (SZ > 1) ? $clog2(SZ) : 1;

  // Current state; left as a named enum so checkers can bind to it.
  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          accept;

  assign in_ready = (state == IDLE) || (state == STREAM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Batch control: stream vectors, then wait for the last lane to launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              if (SZ == 1) begin
                // Single lane: the element is already on a_out, nothing to drain.
                state <= DONE;
              end else begin
                state     <= DRAIN;
                drain_cnt <= CW'(SZ - 1);
              end
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          // The cycle with drain_cnt==0 is the one where the last vector's
          // lane SZ-1 element is on a_out.
          if (drain_cnt == '0) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Triangular delay line: lane j owns j+1 stages; stage j drives the output.
  for (genvar j = 0; j < SZ; j++) begin : g_lane
    logic [DW-1:0] dat [0:j];
    logic [j:0]    vld;

    // Shift lane j every cycle; a non-accept cycle injects a zero bubble.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= j; k++) begin
          dat[k] <= '0;
        end
        vld <= '0;
      end else begin
        dat[0] <= accept ? in_vec[j*DW +: DW] : '0;
        vld[0] <= accept;
        for (int k = 1; k <= j; k++) begin
          dat[k] <= dat[k-1];
          vld[k] <= vld[k-1];
        end
      end
    end

    // Bubbles already carry zero data; the mask guarantees it regardless.
    assign a_out[j*DW +: DW] = vld[j] ? dat[j] : '0;
    assign a_valid[j]        = vld[j];
  end

endmodule
